error_frame_tx: RTL

Downstream of the error/overload detector: turns its active-low error and overload requests into an actual CAN error or overload frame on the transmit bit. Drives the 6-bit flag (active dominant or passive recessive), waits out superimposed flags from other nodes, sends the 8-bit recessive delimiter and times the 3-bit intermission. Sequenced on the bit-rate `samplePoint` clock, so one clock edge equals one bit time.

---
 rtl/error_frame_tx.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/error_frame_tx.sv
// CAN error/overload frame transmitter: flag, superimposed-flag wait, delimiter and intermission.
// Clocked by the bit-rate sample point, so each rising edge is one bit time.
module error_frame_tx #(
    parameter int unsigned FLAG_LEN     = 6,
    parameter int unsigned DELIM_LEN    = 8,
    parameter int unsigned INTER_LEN    = 3,
    parameter int unsigned MAX_OVERLOAD = 2,
    parameter int unsigned EXCESS_LEN   = 8
) (
    input  logic samplePoint,
    input  logic reset,
    input  logic erro,
    input  logic overloadFlag,
    input  logic errorPassive,
    input  logic rxBit,
    output logic txBit,
    output logic frameBusy,
    output logic frameType,
    output logic interframe,
    output logic stuffDisable,
    output logic excessDominant
);

    localparam int CW = 8;

    typedef enum logic [2:0] {StIdle, StFlag, StWaitRec, StDelim, StInter} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] ovl_q, ovl_d;
    logic [CW-1:0] eq_next;
    logic          passive_q, passive_d;
    logic          last_rx_q, last_rx_d;
    logic          ftype_d;
    logic          excess_d;
    logic          ovl_ok;
    logic          start_err, start_ovl;

    // Overload requests beyond the limit are dropped, never remembered.
    assign ovl_ok = !overloadFlag && (ovl_q < CW'(MAX_OVERLOAD));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ovl_d     = ovl_q;
        passive_d = passive_q;
        last_rx_d = last_rx_q;
        ftype_d   = frameType;
        excess_d  = 1'b0;
        eq_next   = '0;
        start_err = 1'b0;
        start_ovl = 1'b0;

        case (state_q)
            StIdle: begin
                if (!erro) start_err = 1'b1;
                else if (ovl_ok) start_ovl = 1'b1;
            end
            StFlag: begin
                if (passive_q) begin
                    // Passive flag ends after FLAG_LEN equal consecutive bus samples.
                    eq_next   = (cnt_q == '0 || rxBit != last_rx_q) ? CW'(1) : cnt_q + CW'(1);
                    last_rx_d = rxBit;
                    if (eq_next == CW'(FLAG_LEN)) begin
                        state_d = StWaitRec;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = eq_next;
                    end
                end else if (cnt_q == CW'(FLAG_LEN - 1)) begin
                    state_d = StWaitRec;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StWaitRec: begin
                if (rxBit) begin
                    state_d = StDelim;
                    cnt_d   = CW'(1);
                end else if (cnt_q + CW'(1) == CW'(EXCESS_LEN)) begin
                    excess_d = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StDelim: begin
                if (!rxBit || !erro) begin
                    start_err = 1'b1;
                end else if (cnt_q == CW'(DELIM_LEN - 1)) begin
                    state_d = StInter;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StInter: begin
                if (!erro) begin
                    start_err = 1'b1;
                end else if (ovl_ok) begin
                    start_ovl = 1'b1;
                end else if (cnt_q == CW'(INTER_LEN - 1)) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    if (overloadFlag) ovl_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        if (start_err) begin
            state_d   = StFlag;
            cnt_d     = '0;
            ftype_d   = 1'b0;
            ovl_d     = '0;
            passive_d = errorPassive;
        end else if (start_ovl) begin
            state_d   = StFlag;
            cnt_d     = '0;
            ftype_d   = 1'b1;
            ovl_d     = ovl_q + CW'(1);
            passive_d = errorPassive;
        end
    end

    always_ff @(posedge samplePoint or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            ovl_q          <= '0;
            passive_q      <= 1'b0;
            last_rx_q      <= 1'b1;
            txBit          <= 1'b1;
            frameBusy      <= 1'b0;
            frameType      <= 1'b0;
            interframe     <= 1'b1;
            stuffDisable   <= 1'b0;
            excessDominant <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            ovl_q          <= ovl_d;
            passive_q      <= passive_d;
            last_rx_q      <= last_rx_d;
            txBit          <= !(state_d == StFlag && !passive_d);
            frameBusy      <= state_d inside {StFlag, StWaitRec, StDelim};
            stuffDisable   <= state_d inside {StFlag, StWaitRec, StDelim};
            frameType      <= ftype_d;
            interframe     <= state_d inside {StIdle, StInter};
            excessDominant <= excess_d;
        end
    end

endmodule
